// File: rtl/dump_trigger_seq.sv
// dump_trigger_seq
// Per-echo sequencer for the dump-off stage of the NMR transmit chain.
// For every echo it waits for the RF transmit pulse to end, counts the
// programmed ring-down delay and then raises state_start for one cycle.
// After the programmed number of echoes it pulses done.
// Optional feature: define DUMP_TRIG_OVERLAP_CHK_EN to flag (err_overlap)
// and discard an echo whose ring-down window is interrupted by a new TX pulse.
// Without the macro, TX is ignored during the delay and err_overlap is 0.
module dump_trigger_seq #(
    parameter int DELAY_W = 8,
    parameter int CNT_W   = 10
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic [CNT_W-1:0]   echo_num,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic               tx_pulse,
    output logic               state_start,
    output logic               busy,
    output logic [CNT_W-1:0]   dump_cnt,
    output logic               done,
    output logic               err_overlap
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TX,
        DELAY,
        FIRE,
        FIN
    } state_t;

    state_t             state;
    logic               tx_d;
    logic               tx_fall;
    logic [CNT_W-1:0]   remain;
    logic [DELAY_W-1:0] dly_set;
    logic [DELAY_W-1:0] dly_cnt;

    // A falling TX edge is seen one cycle after the pulse drops
    assign tx_fall = tx_d & ~tx_pulse;

    // Sequencer: echo bookkeeping, ring-down countdown and registered strobes
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= IDLE;
            tx_d        <= 1'b0;
            remain      <= '0;
            dly_set     <= '0;
            dly_cnt     <= '0;
            dump_cnt    <= '0;
            state_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            tx_d        <= tx_pulse;
            state_start <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            remain   <= echo_num;
                            dly_set  <= delay_cfg;
                            dump_cnt <= '0;
                            busy     <= 1'b1;
                            if (echo_num == '0) begin
                                state <= FIN;
                            end else begin
                                state <= WAIT_TX;
                            end
                        end
                    end
                    WAIT_TX: begin
                        if (tx_fall) begin
                            dly_cnt <= dly_set;
                            state   <= DELAY;
                        end
                    end
                    DELAY: begin
`ifdef DUMP_TRIG_OVERLAP_CHK_EN
                        if (tx_pulse) begin
                            state <= WAIT_TX;
                        end else if (dly_cnt == '0) begin
                            state <= FIRE;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
`else
                        if (dly_cnt == '0) begin
                            state <= FIRE;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
`endif
                    end
                    FIRE: begin
                        state_start <= 1'b1;
                        remain      <= remain - 1'b1;
                        if (dump_cnt != '1) begin
                            dump_cnt <= dump_cnt + 1'b1;
                        end
                        if (remain == CNT_W'(1)) begin
                            state <= FIN;
                        end else begin
                            state <= WAIT_TX;
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DUMP_TRIG_OVERLAP_CHK_EN
    // Sticky overlap flag: set when TX returns inside the ring-down window, cleared by a new arm
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            err_overlap <= 1'b0;
        end else if (!abort && state == IDLE && arm) begin
            err_overlap <= 1'b0;
        end else if (!abort && state == DELAY && tx_pulse) begin
            err_overlap <= 1'b1;
        end
    end
`else
    assign err_overlap = 1'b0;
`endif

endmodule

// File: doc/dump_trigger_seq.md
# dump_trigger_seq

Upstream sequencer for the dump-off stage of the NMR transmit chain. For each echo of a CPMG train it waits for the RF transmit pulse to end, counts a programmable ring-down delay, then issues the one-cycle `state_start` strobe. That strobe launches one dump off/on cycle in the downstream dump stage. The block repeats this for a programmed number of echoes and reports progress and completion to the sequence controller.

## Interface
Parameters:
- `DELAY_W`, 8 — width of the ring-down delay setting, in clk_sys cycles.
- `CNT_W`, 10 — width of the echo count and progress counter.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle start strobe; samples `echo_num` and `delay_cfg`.
- `abort`  in  1  synchronous abort; return to IDLE.
- `echo_num`  in  CNT_W  number of `state_start` strobes to issue.
- `delay_cfg`  in  DELAY_W  ring-down delay after TX falls.
- `tx_pulse`  in  1  RF transmit active (level, synchronous to clk_sys).
- `state_start`  out  1  one-cycle strobe to the dump stage.
- `busy`  out  1  high from the cycle after an accepted `arm` until the sequence ends.
- `dump_cnt`  out  CNT_W  number of strobes issued in the current or last sequence.
- `done`  out  1  one-cycle pulse when the sequence completes normally.
- `err_overlap`  out  1  sticky flag: TX re-asserted during the delay (see Configuration).

## Operation
- All outputs reset to 0.
- Registered `tx_d` holds `tx_pulse` delayed by one cycle. Fall event = `tx_d & ~tx_pulse`.
- `arm` latches `echo_num` into `remain` and `delay_cfg` into `dly_set`, and clears `dump_cnt` and `err_overlap`.
- FSM states: IDLE, WAIT_TX, DELAY, FIRE, FIN.
- IDLE: on `arm`, go to FIN if `echo_num`==0, otherwise go to WAIT_TX.
- WAIT_TX: on a fall event, load `dly_cnt` ← `dly_set` and go to DELAY.
  - The fall must be seen in WAIT_TX. TX already low at arm does not trigger; the block waits for the next fall.
- DELAY: if `dly_cnt`==0, go to FIRE; otherwise decrement.
- FIRE: `state_start`=1 for this cycle only. `dump_cnt`++, `remain`--.
  - If `remain` reaches 0, go to FIN; otherwise go to WAIT_TX.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `busy` = state ≠ IDLE, registered so it aligns with the state.
- `arm` is ignored in every state except IDLE.
- `abort` has priority over every transition. Next state is IDLE with no `done` and no `state_start`. `dump_cnt` keeps its value.
- `rst` mid-sequence clears everything, including `dump_cnt`, on the next edge.
- `dump_cnt` saturates at all-ones and never wraps. `remain` cannot underflow because of the `echo_num`==0 path.

## Timing
- Latency from fall detection to strobe: `state_start` is high in the cycle starting `delay_cfg`+2 rising edges after the first edge that samples `tx_pulse`=0 with `tx_d`=1.
- Latency from `arm` to `done` with `echo_num`=0: `done` is high in the second cycle after the `arm` edge.
- Minimum strobe spacing equals the TX pulse period. No internal spacing is enforced.
- A fall event landing in the FIRE cycle is lost. The upstream sequence guarantees TX on-time ≥ 2 cycles.

## Configuration
- Macro `DUMP_TRIG_OVERLAP_CHK_EN`, defined:
  - In DELAY, `tx_pulse`=1 sets `err_overlap`.
  - That echo is discarded (no strobe, no count) and the FSM returns to WAIT_TX.
- Macro undefined:
  - `tx_pulse` is ignored in DELAY.
  - `err_overlap` is tied to 0.

## Test plan
- Single echo: `echo_num`=1, `delay_cfg`=5, TX high 10 cycles. Required: exactly one `state_start`, 7 cycles after the fall-detecting edge; then `done` one cycle later; `dump_cnt`=1; `busy` then drops.
- Train: `echo_num`=4, `delay_cfg`=0, four TX pulses. Required: four strobes, each 2 cycles after its fall; then `done`; `dump_cnt`=4.
- Zero count: `arm` with `echo_num`=0. Required: no `state_start`; `done` 2 cycles after arm; `dump_cnt`=0.
- Abort and re-arm: abort during DELAY of echo 2 of 3. Required: IDLE next cycle, no strobe, no `done`, `dump_cnt`=1. Arm ignored while `busy`; a new arm after abort works.
- Overlap, macro on: TX re-rises during DELAY. Required: `err_overlap`=1 and stays set, that echo is not counted, and the next clean fall yields a strobe.
- Overlap, macro off: same stimulus. Required: the strobe fires on schedule and `err_overlap`=0.
- Reset mid-sequence: assert `rst` during WAIT_TX. Required: all outputs 0 on the next edge.
